// File: rtl/sap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sap_pkg
// Description : Shared opcodes, T-state encodings and control-word layout for
//               the SAP CPU control sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    localparam int CW_WIDTH = 16;
    localparam int CW_HLT   = 15;
    localparam int CW_MI    = 14;
    localparam int CW_RI    = 13;
    localparam int CW_RO    = 12;
    localparam int CW_IO    = 11;
    localparam int CW_II    = 10;
    localparam int CW_AI    = 9;
    localparam int CW_AO    = 8;
    localparam int CW_EO    = 7;
    localparam int CW_SU    = 6;
    localparam int CW_BI    = 5;
    localparam int CW_OI    = 4;
    localparam int CW_CE    = 3;
    localparam int CW_CO    = 2;
    localparam int CW_J     = 1;
    localparam int CW_FI    = 0;

    // All _n strobes high, hlt/su/ce low.
    localparam logic [CW_WIDTH-1:0] CW_INACTIVE = 16'h7FB7;

    // One-hot "asserted" mask for a control bit; XOR with CW_INACTIVE gives
    // the physical polarity.
    function automatic logic [CW_WIDTH-1:0] cw_bit(input int idx);
        return CW_WIDTH'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_counter.sv
`default_nettype none
// ============================================================================
// Module      : step_counter
// Description : T-state counter with enable, early-wrap request and
//               MAX_STEPS rollover.
// Revision    : 1.0 - initial release
// ============================================================================
module step_counter #(
    parameter int MAX_STEPS = 5,
    parameter int WIDTH     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             wrap,
    output logic [WIDTH-1:0] step
);

    localparam logic [WIDTH-1:0] c_last = WIDTH'(MAX_STEPS - 1);

    logic [WIDTH-1:0] r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_step <= '0;
        end else if (en) begin
            if (wrap || (r_step == c_last)) begin
                r_step <= '0;
            end else begin
                r_step <= r_step + WIDTH'(1);
            end
        end
    end

    assign step = r_step;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Microcoded control unit for the 8-bit SAP CPU: steps T-states,
//               decodes the opcode and drives all datapath strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import sap_pkg::*;
#(
    parameter int MAX_STEPS = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [1:0] flags,
    output logic       hlt,
    output logic       mi_n,
    output logic       ri_n,
    output logic       ro_n,
    output logic       io_n,
    output logic       ii_n,
    output logic       ai_n,
    output logic       ao_n,
    output logic       eo_n,
    output logic       su,
    output logic       bi_n,
    output logic       oi_n,
    output logic       ce,
    output logic       co_n,
    output logic       j_n,
    output logic       fi_n,
    output logic [2:0] step
);

    logic                r_halted;
    logic [2:0]          w_step;
    logic [2:0]          w_last_step;
    logic [CW_WIDTH-1:0] w_active;
    logic [CW_WIDTH-1:0] w_cw;
    logic                w_halt_set;
    logic                w_en;
    logic                w_wrap;

    step_counter #(
        .MAX_STEPS (MAX_STEPS),
        .WIDTH     (3)
    ) u_step_counter (
        .clk   (clk),
        .reset (reset),
        .en    (w_en),
        .wrap  (w_wrap),
        .step  (w_step)
    );

    assign w_halt_set = !r_halted && (w_step == T2) && (opcode == OP_HLT);
    assign w_en       = !r_halted && !w_halt_set;
    assign w_wrap     = EARLY_END && (w_step == w_last_step);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_halt_set) begin
            r_halted <= 1'b1;
        end
    end

    // Last active step per opcode; a not-taken conditional jump still ends at T2.
    always_comb begin
        w_last_step = T1;
        case (opcode)
            OP_LDA, OP_STA:                             w_last_step = T3;
            OP_ADD, OP_SUB:                             w_last_step = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: w_last_step = T2;
            default:                                    w_last_step = T1;
        endcase
    end

    always_comb begin
        w_active = '0;
        if (r_halted) begin
            w_active = cw_bit(CW_HLT);
        end else if (w_step == T0) begin
            w_active = cw_bit(CW_CO) | cw_bit(CW_MI);
        end else if (w_step == T1) begin
            w_active = cw_bit(CW_RO) | cw_bit(CW_II) | cw_bit(CW_CE);
        end else begin
            case ({opcode, w_step})
                {OP_LDA, T2}, {OP_ADD, T2}, {OP_SUB, T2}, {OP_STA, T2}:
                    w_active = cw_bit(CW_IO) | cw_bit(CW_MI);
                {OP_LDA, T3}: w_active = cw_bit(CW_RO) | cw_bit(CW_AI);
                {OP_ADD, T3}, {OP_SUB, T3}:
                    w_active = cw_bit(CW_RO) | cw_bit(CW_BI);
                {OP_ADD, T4}: w_active = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI);
                {OP_SUB, T4}: w_active = cw_bit(CW_EO) | cw_bit(CW_AI) | cw_bit(CW_FI)
                                       | cw_bit(CW_SU);
                {OP_STA, T3}: w_active = cw_bit(CW_AO) | cw_bit(CW_RI);
                {OP_LDI, T2}: w_active = cw_bit(CW_IO) | cw_bit(CW_AI);
                {OP_JMP, T2}: w_active = cw_bit(CW_IO) | cw_bit(CW_J);
                {OP_JC, T2}:  w_active = flags[0] ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                {OP_JZ, T2}:  w_active = flags[1] ? (cw_bit(CW_IO) | cw_bit(CW_J)) : '0;
                {OP_OUT, T2}: w_active = cw_bit(CW_AO) | cw_bit(CW_OI);
                {OP_HLT, T2}: w_active = cw_bit(CW_HLT);
                default:      w_active = '0;
            endcase
        end
    end

    // Reset gates the strobes immediately, not just from the next edge.
    assign w_cw = reset ? CW_INACTIVE : (CW_INACTIVE ^ w_active);

    assign hlt  = w_cw[CW_HLT];
    assign mi_n = w_cw[CW_MI];
    assign ri_n = w_cw[CW_RI];
    assign ro_n = w_cw[CW_RO];
    assign io_n = w_cw[CW_IO];
    assign ii_n = w_cw[CW_II];
    assign ai_n = w_cw[CW_AI];
    assign ao_n = w_cw[CW_AO];
    assign eo_n = w_cw[CW_EO];
    assign su   = w_cw[CW_SU];
    assign bi_n = w_cw[CW_BI];
    assign oi_n = w_cw[CW_OI];
    assign ce   = w_cw[CW_CE];
    assign co_n = w_cw[CW_CO];
    assign j_n  = w_cw[CW_J];
    assign fi_n = w_cw[CW_FI];
    assign step = w_step;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Scoreboard bench for control_sequencer, EARLY_END=1 and =0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;

    localparam int B_HLT = 15, B_MI = 14, B_RI = 13, B_RO = 12, B_IO = 11, B_II = 10;
    localparam int B_AI  = 9,  B_AO = 8,  B_EO = 7,  B_SU = 6,  B_BI = 5,  B_OI = 4;
    localparam int B_CE  = 3,  B_CO = 2,  B_J  = 1,  B_FI = 0;

    typedef struct {
        logic [15:0] mask;
        logic        chk;
        logic [2:0]  step;
    } exp_t;

    exp_t q[$];

    logic       clk = 1'b0;
    logic       sel = 1'b0;
    logic       nsel = 1'b0;
    logic       r = 1'b1;
    logic       done = 1'b0;
    logic [3:0] opcode = 4'h0;
    logic [1:0] flags = 2'b00;
    logic       reset_e, reset_f;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    assign reset_e = sel ? 1'b1 : r;
    assign reset_f = sel ? r : 1'b1;

    logic e_hlt, e_mi_n, e_ri_n, e_ro_n, e_io_n, e_ii_n, e_ai_n, e_ao_n;
    logic e_eo_n, e_su, e_bi_n, e_oi_n, e_ce, e_co_n, e_j_n, e_fi_n;
    logic f_hlt, f_mi_n, f_ri_n, f_ro_n, f_io_n, f_ii_n, f_ai_n, f_ao_n;
    logic f_eo_n, f_su, f_bi_n, f_oi_n, f_ce, f_co_n, f_j_n, f_fi_n;
    logic [2:0] e_step, f_step;

    control_sequencer #(.MAX_STEPS(5), .EARLY_END(1'b1)) dut_e (
        .clk(clk), .reset(reset_e), .opcode(opcode), .flags(flags),
        .hlt(e_hlt), .mi_n(e_mi_n), .ri_n(e_ri_n), .ro_n(e_ro_n), .io_n(e_io_n),
        .ii_n(e_ii_n), .ai_n(e_ai_n), .ao_n(e_ao_n), .eo_n(e_eo_n), .su(e_su),
        .bi_n(e_bi_n), .oi_n(e_oi_n), .ce(e_ce), .co_n(e_co_n), .j_n(e_j_n),
        .fi_n(e_fi_n), .step(e_step)
    );

    control_sequencer #(.MAX_STEPS(5), .EARLY_END(1'b0)) dut_f (
        .clk(clk), .reset(reset_f), .opcode(opcode), .flags(flags),
        .hlt(f_hlt), .mi_n(f_mi_n), .ri_n(f_ri_n), .ro_n(f_ro_n), .io_n(f_io_n),
        .ii_n(f_ii_n), .ai_n(f_ai_n), .ao_n(f_ao_n), .eo_n(f_eo_n), .su(f_su),
        .bi_n(f_bi_n), .oi_n(f_oi_n), .ce(f_ce), .co_n(f_co_n), .j_n(f_j_n),
        .fi_n(f_fi_n), .step(f_step)
    );

    // Observed strobes as "asserted" bits, independent of pin polarity.
    logic [15:0] obs_e, obs_f, obs;
    logic [2:0]  step_obs;
    assign obs_e = {e_hlt, ~e_mi_n, ~e_ri_n, ~e_ro_n, ~e_io_n, ~e_ii_n, ~e_ai_n, ~e_ao_n,
                    ~e_eo_n, e_su, ~e_bi_n, ~e_oi_n, e_ce, ~e_co_n, ~e_j_n, ~e_fi_n};
    assign obs_f = {f_hlt, ~f_mi_n, ~f_ri_n, ~f_ro_n, ~f_io_n, ~f_ii_n, ~f_ai_n, ~f_ao_n,
                    ~f_eo_n, f_su, ~f_bi_n, ~f_oi_n, f_ce, ~f_co_n, ~f_j_n, ~f_fi_n};
    assign obs      = sel ? obs_f : obs_e;
    assign step_obs = sel ? f_step : e_step;

    function automatic logic [15:0] b(input int i);
        return 16'(1) << i;
    endfunction

    // Reference: what an instruction asserts at step k, given flags seen at T2.
    function automatic logic [15:0] micro(input logic [3:0] op, input int k,
                                          input logic [1:0] f);
        logic [15:0] m;
        m = '0;
        if (k == 0) m = b(B_CO) | b(B_MI);
        else if (k == 1) m = b(B_RO) | b(B_II) | b(B_CE);
        else if (k == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: m = b(B_IO) | b(B_MI);
                4'h5: m = b(B_IO) | b(B_AI);
                4'h6: m = b(B_IO) | b(B_J);
                4'h7: m = f[0] ? (b(B_IO) | b(B_J)) : 16'h0;
                4'h8: m = f[1] ? (b(B_IO) | b(B_J)) : 16'h0;
                4'hE: m = b(B_AO) | b(B_OI);
                4'hF: m = b(B_HLT);
                default: m = '0;
            endcase
        end else if (k == 3) begin
            case (op)
                4'h1: m = b(B_RO) | b(B_AI);
                4'h2, 4'h3: m = b(B_RO) | b(B_BI);
                4'h4: m = b(B_AO) | b(B_RI);
                default: m = '0;
            endcase
        end else if (k == 4) begin
            if (op == 4'h2) m = b(B_EO) | b(B_AI) | b(B_FI);
            else if (op == 4'h3) m = b(B_EO) | b(B_AI) | b(B_FI) | b(B_SU);
        end
        return m;
    endfunction

    function automatic int last_step(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 3;
            4'h2, 4'h3: return 4;
            4'h5, 4'h6, 4'h7, 4'h8, 4'hE, 4'hF: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic push(input logic [15:0] m, input logic chk, input logic [2:0] s);
        exp_t e;
        e.mask = m;
        e.chk  = chk;
        e.step = s;
        q.push_back(e);
    endtask

    task automatic cyc(input logic rv, input logic [3:0] op, input logic [1:0] fl);
        @(posedge clk);
        #1;
        sel    = nsel;
        r      = rv;
        opcode = op;
        flags  = fl;
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            cyc(1'b1, 4'($urandom), 2'($urandom));
            push(16'h0, 1'b0, 3'd0);
        end
    endtask

    // cut>0 aborts after that many cycles with a reset; hold = halted cycles.
    task automatic do_instr(input logic [3:0] op, input logic [1:0] f2, input int cut,
                            input int hold);
        int         len;
        logic [1:0] fl;
        if (op == 4'hF) begin
            for (int k = 0; k < 3; k++) begin
                fl = (k == 2) ? f2 : 2'($urandom);
                cyc(1'b0, op, fl);
                push(micro(op, k, f2), 1'b1, 3'(k));
            end
            for (int k = 0; k < hold; k++) begin
                cyc(1'b0, 4'($urandom), 2'($urandom));
                push(b(B_HLT), 1'b1, 3'd2);
            end
            do_reset($urandom_range(1, 2));
        end else begin
            len = (nsel == 1'b0) ? last_step(op) + 1 : 5;
            if (cut > 0 && cut < len) len = cut;
            for (int k = 0; k < len; k++) begin
                fl = (k == 2) ? f2 : 2'($urandom);
                cyc(1'b0, op, fl);
                push(micro(op, k, f2), 1'b1, 3'(k));
            end
            if (cut > 0) do_reset($urandom_range(1, 2));
        end
    endtask

    task automatic random_run(input int n);
        logic [3:0] op;
        int         cut;
        for (int i = 0; i < n; i++) begin
            op  = 4'($urandom);
            cut = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 4) : 0;
            do_instr(op, 2'($urandom), cut, $urandom_range(1, 6));
        end
    endtask

    initial begin
        do_reset(2);
        do_instr(4'h2, 2'b00, 0, 0);
        do_instr(4'h3, 2'b11, 0, 0);
        do_instr(4'h1, 2'b00, 0, 0);
        do_instr(4'h7, 2'b01, 0, 0);
        do_instr(4'h7, 2'b00, 0, 0);
        do_instr(4'h8, 2'b10, 0, 0);
        do_instr(4'h8, 2'b00, 0, 0);
        do_instr(4'h0, 2'b11, 0, 0);
        do_instr(4'h4, 2'b00, 0, 0);
        do_instr(4'hE, 2'b00, 0, 0);
        do_instr(4'hB, 2'b11, 0, 0);
        do_instr(4'hF, 2'b00, 0, 10);
        random_run(60);
        nsel = 1'b1;
        do_reset(2);
        do_instr(4'h5, 2'b00, 0, 0);
        do_instr(4'h2, 2'b00, 3, 0);
        do_instr(4'h7, 2'b00, 0, 0);
        do_instr(4'h2, 2'b11, 0, 0);
        do_instr(4'hF, 2'b00, 0, 4);
        random_run(40);
        done = 1'b1;
    end

    initial begin
        exp_t e;
        int   n_cyc;
        n_cyc = 0;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (obs !== e.mask)
                    $display("FAIL ctl_word t=%0t got=%h want=%h", $time, obs, e.mask);
                if (obs !== e.mask) failures++;
                if (e.chk) begin
                    checks++;
                    if (step_obs !== e.step) begin
                        failures++;
                        $display("FAIL step t=%0t got=%0d want=%0d", $time, step_obs, e.step);
                    end
                    checks++;
                    if ($countones({obs[B_CO], obs[B_RO], obs[B_IO], obs[B_AO], obs[B_EO]}) > 1)
                    begin
                        failures++;
                        $display("FAIL bus_invariant t=%0t got=%h want=at_most_one_driver",
                                 $time, obs);
                    end
                end
            end
            if (done && q.size() == 0) break;
            if (n_cyc > 20000) begin
                failures++;
                $display("FAIL timeout got=%0d_pending want=0", q.size());
                break;
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
